decode_wb_fwd_param: RTL and testbench
======================================

Name: decode_wb_fwd_param

Overview:
- Parametrised successor to the pipeline decode/write-back stage of the Y86-64 core.
- Contains:
  - the architectural register file, with two independent write ports (W_dstE and W_dstM);
  - source/destination decode for all Y86 icodes;
  - a 5-source forwarding network;
  - load-use hazard detection;
  - the D→E pipeline register, with stall, bubble and synchronous reset.
- Replaces the per-register debug outputs with an addressed debug read port.

Parameters:
- DATA_W, 64, width of register values, valC, valP and forwarded values.
- RSP_INIT, 0, value loaded into %rsp (register 4) at reset.
- NONE_ID, 4'hF, register ID meaning "no register"; never written, never forwarded.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- D_stat  in  2  fetch status.
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decode-stage instruction fields.
- D_valC, D_valP  in  DATA_W each  constant and next PC.
- e_dstE  in  4  execute-stage forwarding destination.
- e_valE  in  DATA_W  execute-stage forwarding value.
- M_dstE, M_dstM  in  4 each  memory-stage forwarding destinations.
- M_valE, m_valM  in  DATA_W each  memory-stage forwarding values.
- W_dstE, W_dstM  in  4 each  write-back destinations; these are also the register-file write addresses.
- W_valE, W_valM  in  DATA_W each  write-back values.
- E_stall  in  1  hold the E register.
- E_bubble  in  1  load a nop into the E register.
- d_srcA, d_srcB  out  4 each  decoded sources (combinational).
- d_valA, d_valB  out  DATA_W each  forwarded operands (combinational).
- load_use  out  1  combinational load-use hazard flag.
- E_stat  out  2  E-register status.
- E_icode, E_ifun  out  4 each  E-register instruction fields.
- E_valC, E_valA, E_valB  out  DATA_W each  E-register values.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  E-register register IDs.
- dbg_addr  in  4  debug read address.
- dbg_data  out  DATA_W  register-file contents at dbg_addr (combinational). Returns 0 when dbg_addr = NONE_ID.

Behaviour:

Decode table (srcA, srcB, dstE, dstM). All fields are NONE_ID unless listed.
- cmovXX (2): srcA=rA, dstE=rB.
- irmovq (3): dstE=rB.
- rmmovq (4): srcA=rA, srcB=rB.
- mrmovq (5): srcB=rB, dstM=rA.
- OPq (6): srcA=rA, srcB=rB, dstE=rB.
- call (8): srcB=4, dstE=4.
- ret (9): srcA=4, srcB=4, dstE=4.
- pushq (A): srcA=rA, srcB=4, dstE=4.
- popq (B): srcA=4, srcB=4, dstE=4, dstM=rA.
- halt, nop, jXX and any invalid icode: all fields NONE_ID.

d_valA priority (first match wins):
1. D_icode in {7, 8} → D_valP.
2. d_srcA == e_dstE → e_valE.
3. d_srcA == M_dstM → m_valM.
4. d_srcA == M_dstE → M_valE.
5. d_srcA == W_dstM → W_valM.
6. d_srcA == W_dstE → W_valE.
7. Otherwise → regfile[d_srcA].
- A match is valid only if the source is not NONE_ID.
- A NONE_ID source with no earlier match yields 0.

d_valB: same chain as d_valA, minus the valP step.

load_use:
- Asserted when E_icode is in {5, B}, E_dstM != NONE_ID, and E_dstM equals d_srcA or d_srcB.
- The block only reports the hazard; stall/bubble generation belongs to the hazard control unit.

Write-back (posedge clk, rst=0):
- If W_dstE != NONE_ID: regfile[W_dstE] ← W_valE.
- If W_dstM != NONE_ID: regfile[W_dstM] ← W_valM.
- If W_dstE == W_dstM (e.g. popq %rsp): the M write wins.
- Writes are independent of icode.
- A same-cycle read of a register being written returns the new value, through forwarding steps 5/6.

E register (posedge clk), priority rst > E_bubble > E_stall > load:
- rst: regfile[i]=0 for all i, except regfile[4]=RSP_INIT. E register takes the bubble value.
- Bubble value:
  - E_icode=1, E_ifun=0, E_stat=0.
  - E_valA, E_valB, E_valC = 0.
  - E_dstE, E_dstM, E_srcA, E_srcB = NONE_ID.
- Stall: all E outputs hold.
- Load: E_* ← {D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB}.
- Latency: decode result appears on E_* one cycle after it is presented.
- Reset mid-operation: wins over pending write-back, and the W write of that cycle is discarded.

Test Plan:
- Reset with RSP_INIT=0x100: after one clk, dbg_addr=4 → 0x100; dbg_addr=0 → 0; E_icode=1; E_dstE=F.
- W_dstE=2/W_valE=7 and W_dstM=3/W_valM=9 in the same cycle; next cycle dbg shows r2=7 and r3=9. Repeat with W_dstE=W_dstM=4, W_valE=1, W_valM=2 → r4=2.
- OPq rA=1 rB=2 with e_dstE=1 (e_valE=0xAA), M_dstE=1 (M_valE=0xBB), W_dstE=2 (W_valE=0xCC) → d_valA=0xAA, d_valB=0xCC.
- call: D_valP=0x40, r4=0x100 → d_valA=0x40, d_valB=0x100, dstE=4. The next clk latches E_valA=0x40.
- E_icode=5, E_dstM=3 with D_icode=6, rA=3 → load_use=1. With E_bubble=1 and E_stall=1 both asserted, E_icode becomes 1.
- E_stall=1 for 2 cycles while D_* changes → E_* unchanged. On release, E_* loads the current D values.

Source files
------------

// File: rtl/decode_wb_fwd_param.sv
// Y86-64 decode / write-back stage: dual-write register file, source/destination
// decode, five-source operand forwarding, load-use detection and the D->E register.
module decode_wb_fwd_param #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RSP_INIT = '0,
  parameter logic [3:0]        NONE_ID  = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              E_stall,
  input  logic              E_bubble,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [DATA_W-1:0] d_valA,
  output logic [DATA_W-1:0] d_valB,
  output logic              load_use,
  output logic [1:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_RSP    = 4'h4;

  logic [15:0][DATA_W-1:0] rf_q;
  logic [3:0]              d_dstE;
  logic [3:0]              d_dstM;

  // One flop bank per register; the M port is tested first so it wins a same-address collision.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_rf
      logic [DATA_W-1:0] val_reg;
      always_ff @(posedge clk) begin
        if (rst)
          val_reg <= (gi == 4) ? RSP_INIT : '0;
        else if (W_dstM == 4'(gi) && W_dstM != NONE_ID)
          val_reg <= W_valM;
        else if (W_dstE == 4'(gi) && W_dstE != NONE_ID)
          val_reg <= W_valE;
      end
      assign rf_q[gi] = val_reg;
    end
  endgenerate

  always_comb begin
    d_srcA = NONE_ID;
    d_srcB = NONE_ID;
    d_dstE = NONE_ID;
    d_dstM = NONE_ID;
    case (D_icode)
      I_CMOV:   begin d_srcA = D_rA; d_dstE = D_rB; end
      I_IRMOVQ: d_dstE = D_rB;
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      I_CALL:   begin d_srcB = R_RSP; d_dstE = R_RSP; end
      I_RET:    begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = R_RSP; d_dstE = R_RSP; end
      I_POPQ:   begin d_srcA = R_RSP; d_srcB = R_RSP; d_dstE = R_RSP; d_dstM = D_rA; end
      default:  ;
    endcase
  end

  // Operand A (gi=0) and B (gi=1) share the forwarding chain; only A takes valP.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [3:0]        src;
      logic [DATA_W-1:0] val;
      assign src = (gi == 0) ? d_srcA : d_srcB;
      always_comb begin
        val = '0;
        if (gi == 0 && (D_icode == I_JXX || D_icode == I_CALL))
          val = D_valP;
        else if (src == NONE_ID)
          val = '0;
        else if (src == e_dstE)
          val = e_valE;
        else if (src == M_dstM)
          val = m_valM;
        else if (src == M_dstE)
          val = M_valE;
        else if (src == W_dstM)
          val = W_valM;
        else if (src == W_dstE)
          val = W_valE;
        else
          val = rf_q[src];
      end
    end
  endgenerate

  assign d_valA = g_fwd[0].val;
  assign d_valB = g_fwd[1].val;

  assign load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != NONE_ID) &&
                    (E_dstM == d_srcA || E_dstM == d_srcB);

  assign dbg_data = (dbg_addr == NONE_ID) ? '0 : rf_q[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      E_stat  <= 2'd0;
      E_icode <= I_NOP;
      E_ifun  <= 4'd0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= NONE_ID;
      E_dstM  <= NONE_ID;
      E_srcA  <= NONE_ID;
      E_srcB  <= NONE_ID;
    end else if (!E_stall) begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_wb_fwd_param.sv
// Directed bench for decode_wb_fwd_param with hand-computed expectations.
module tb_decode_wb_fwd_param;

  localparam logic [3:0] NONE = 4'hF;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_stall, E_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_valA, d_valB;
  logic        load_use;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  decode_wb_fwd_param #(.DATA_W(64), .RSP_INIT(64'h100), .NONE_ID(4'hF)) dut (
    .clk(clk), .rst(rst),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_valA(d_valA), .d_valB(d_valB),
    .load_use(load_use),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
    n_cmp++;
    if (obs !== exp_val) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    e_dstE = NONE; M_dstE = NONE; M_dstM = NONE; W_dstE = NONE; W_dstM = NONE;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
    D_stat = 2'd0; D_icode = icode; D_ifun = 4'd0; D_rA = ra; D_rB = rb;
    D_valC = valc; D_valP = valp;
  endtask

  initial begin
    rst = 1'b1; E_stall = 1'b0; E_bubble = 1'b0; dbg_addr = 4'd0;
    clear_fwd();
    set_d(4'h1, NONE, NONE, 64'h0, 64'h0);
    tick();
    rst = 1'b0;

    // Reset state
    dbg_addr = 4'd4; #1 check("reset_r4", dbg_data, 64'h100);
    dbg_addr = 4'd0; #1 check("reset_r0", dbg_data, 64'h0);
    check("reset_E_icode", 64'(E_icode), 64'h1);
    check("reset_E_dstE", 64'(E_dstE), 64'hF);

    // Dual write-back to different registers
    W_dstE = 4'd2; W_valE = 64'd7; W_dstM = 4'd3; W_valM = 64'd9;
    tick();
    clear_fwd();
    dbg_addr = 4'd2; #1 check("wb_r2", dbg_data, 64'd7);
    dbg_addr = 4'd3; #1 check("wb_r3", dbg_data, 64'd9);

    // Same-address write: M port wins; same-cycle read sees it via forwarding
    W_dstE = 4'd4; W_valE = 64'd1; W_dstM = 4'd4; W_valM = 64'd2;
    set_d(4'h2, 4'd4, 4'd6, 64'h0, 64'h0);
    #1 check("fwd_W_same_cycle", d_valA, 64'd2);
    tick();
    clear_fwd();
    dbg_addr = 4'd4; #1 check("wb_collide_r4", dbg_data, 64'd2);

    // Restore %rsp for the call test
    W_dstE = 4'd4; W_valE = 64'h100;
    tick();
    clear_fwd();

    // OPq forwarding priority: e beats M for A, W supplies B
    set_d(4'h6, 4'd1, 4'd2, 64'h0, 64'h0);
    e_dstE = 4'd1; e_valE = 64'hAA;
    M_dstE = 4'd1; M_valE = 64'hBB;
    W_dstE = 4'd2; W_valE = 64'hCC;
    #1;
    check("opq_srcA", 64'(d_srcA), 64'd1);
    check("opq_srcB", 64'(d_srcB), 64'd2);
    check("opq_valA", d_valA, 64'hAA);
    check("opq_valB", d_valB, 64'hCC);
    clear_fwd();

    // NONE source with no forwarding yields zero
    set_d(4'h0, 4'd3, 4'd3, 64'h0, 64'h0);
    #1 check("halt_valA", d_valA, 64'h0);

    // call: valA is valP, valB reads %rsp
    set_d(4'h8, NONE, NONE, 64'h0, 64'h40);
    #1;
    check("call_valA", d_valA, 64'h40);
    check("call_valB", d_valB, 64'h100);
    tick();
    check("call_E_valA", E_valA, 64'h40);
    check("call_E_dstE", 64'(E_dstE), 64'd4);
    check("call_E_icode", 64'(E_icode), 64'h8);

    // mrmovq into E, then dependent OPq raises load_use
    set_d(4'h5, 4'd3, 4'd1, 64'h10, 64'h0);
    tick();
    check("mrmov_E_dstM", 64'(E_dstM), 64'd3);
    set_d(4'h6, 4'd3, 4'd0, 64'h0, 64'h0);
    #1 check("load_use_hit", 64'(load_use), 64'd1);
    set_d(4'h6, 4'd2, 4'd0, 64'h0, 64'h0);
    #1 check("load_use_miss", 64'(load_use), 64'd0);
    set_d(4'h6, 4'd3, 4'd0, 64'h0, 64'h0);
    E_bubble = 1'b1; E_stall = 1'b1;
    tick();
    E_bubble = 1'b0; E_stall = 1'b0;
    check("bubble_E_icode", 64'(E_icode), 64'h1);
    check("bubble_E_dstM", 64'(E_dstM), 64'hF);

    // Stall holds E for two cycles while D changes, then loads current D
    set_d(4'h3, NONE, 4'd5, 64'h55, 64'h0);
    tick();
    check("irmov_E_dstE", 64'(E_dstE), 64'd5);
    E_stall = 1'b1;
    set_d(4'h6, 4'd1, 4'd2, 64'h99, 64'h0);
    tick();
    tick();
    check("stall_E_icode", 64'(E_icode), 64'h3);
    check("stall_E_valC", E_valC, 64'h55);
    check("stall_E_dstE", 64'(E_dstE), 64'd5);
    E_stall = 1'b0;
    tick();
    check("release_E_icode", 64'(E_icode), 64'h6);
    check("release_E_valC", E_valC, 64'h99);
    check("release_E_srcA", 64'(E_srcA), 64'd1);

    // popq decode
    set_d(4'hB, 4'd3, NONE, 64'h0, 64'h0);
    tick();
    check("popq_E_dstE", 64'(E_dstE), 64'd4);
    check("popq_E_dstM", 64'(E_dstM), 64'd3);

    // Reset discards a concurrent write-back
    W_dstE = 4'd1; W_valE = 64'h77;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_fwd();
    dbg_addr = 4'd1; #1 check("rst_drops_wb", dbg_data, 64'h0);
    dbg_addr = 4'd2; #1 check("rst_clears_r2", dbg_data, 64'h0);
    dbg_addr = NONE; #1 check("dbg_none", dbg_data, 64'h0);
    check("rst_E_icode", 64'(E_icode), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
